// File: rtl/exu_types_pkg.sv
// Shared EXU divider types: operation encoding and divider FSM states.
package exu_types_pkg;

  typedef enum logic [2:0] {
    DIV_NONE = 3'd0,
    DIV      = 3'd1,
    DIVU     = 3'd2,
    REM      = 3'd3,
    REMU     = 3'd4
  } riscv_div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_CORR,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/param_nr_divider_step.sv
// One non-restoring division step on a {remainder, quotient} pair; chained for multi-bit retire.
module nr_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs;

  // Sum fits WIDTH+1 bits because the step result lies in [-divisor, divisor).
  always_comb begin
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    dvs      = {1'b0, divisor};
    rem_next = rem[WIDTH] ? shifted + dvs : shifted - dvs;
    quo_next = {quo[WIDTH-2:0], ~rem_next[WIDTH]};
  end

endmodule

// File: rtl/param_nr_divider.sv
// Iterative non-restoring DIV/DIVU/REM/REMU with early-out, tag pass-through and flush.
module param_nr_divider
  import exu_types_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned EARLY_OUT      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_a,
  input  logic [WIDTH-1:0]                  in_b,
  input  logic [$bits(riscv_div_op_e)-1:0]  in_op,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_result,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              busy
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state, state_next;
  riscv_div_op_e    op_q;
  logic [WIDTH-1:0] a_q, b_q, quo_q, div_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] count_q;
  logic             neg_quo_q, neg_rem_q, want_rem_q;
  logic             accept;

  logic             signed_op, want_rem, sign_a, sign_b, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_result;

  // Operand conditioning and special-case detection, consumed in S_PREP.
  always_comb begin
    signed_op      = (op_q == DIV) || (op_q == REM);
    want_rem       = (op_q == REM) || (op_q == REMU);
    sign_a         = signed_op && a_q[WIDTH-1];
    sign_b         = signed_op && b_q[WIDTH-1];
    abs_a          = sign_a ? -a_q : a_q;
    abs_b          = sign_b ? -b_q : b_q;
    special        = 1'b1;
    special_result = '0;
    if (!(op_q inside {DIV, DIVU, REM, REMU}))
      special_result = '0;
    else if (b_q == '0)
      special_result = want_rem ? a_q : '1;
    else if (signed_op && (a_q == MIN_NEG) && (b_q == '1))
      special_result = want_rem ? '0 : a_q;
    else if ((EARLY_OUT != 0) && (abs_a < abs_b))
      special_result = want_rem ? a_q : '0;
    else
      special = 1'b0;
  end

  logic [WIDTH:0]   rem_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    nr_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_chain[i]),
      .quo      (quo_chain[i]),
      .divisor  (div_q),
      .rem_next (rem_chain[i+1]),
      .quo_next (quo_chain[i+1])
    );
  end

  logic [WIDTH-1:0] rem_mag, quo_fix, rem_fix, corr_result;

  // Final restore is done modulo 2^WIDTH; the corrected remainder is always in [0, divisor).
  always_comb begin
    rem_mag     = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + div_q : rem_q[WIDTH-1:0];
    quo_fix     = neg_quo_q ? -quo_q : quo_q;
    rem_fix     = neg_rem_q ? -rem_mag : rem_mag;
    corr_result = want_rem_q ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_PREP;
      S_PREP:  state_next = special ? S_DONE : S_CALC;
      S_CALC:  if (count_q == CNT_W'(1)) state_next = S_CORR;
      S_CORR:  state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !flush;
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= DIV_NONE;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      count_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          a_q     <= in_a;
          b_q     <= in_b;
          op_q    <= riscv_div_op_e'(in_op);
          out_tag <= in_tag;
        end
        S_PREP: begin
          rem_q      <= '0;
          quo_q      <= abs_a;
          div_q      <= abs_b;
          count_q    <= CNT_W'(STEPS);
          neg_quo_q  <= sign_a ^ sign_b;
          neg_rem_q  <= sign_a;
          want_rem_q <= want_rem;
          if (special) out_result <= special_result;
        end
        S_CALC: begin
          rem_q   <= rem_chain[BITS_PER_CYCLE];
          quo_q   <= quo_chain[BITS_PER_CYCLE];
          count_q <= count_q - CNT_W'(1);
        end
        S_CORR:  out_result <= corr_result;
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_param_nr_divider.sv
// Scoreboarded bench: several divider configurations driven in parallel against an arithmetic model.
`timescale 1ns/1ps
module tb_param_nr_divider;
  import exu_types_pkg::*;

  localparam int NCFG  = 7;
  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0] res;
    logic [63:0] tag;
    int          lat;
    int          acc;
  } exp_t;

  function automatic int cfg_w(int i);
    return (i < 4) ? 32 : 16;
  endfunction
  function automatic int cfg_b(int i);
    case (i)
      0, 3, 4: return 1;
      1, 5:    return 2;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_e(int i);
    return (i == 3 || i == 5) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W    = cfg_w(g);
    localparam int BPC  = cfg_b(g);
    localparam int EO   = cfg_e(g);
    localparam int NORM = W / BPC + 3;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic             rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [W-1:0]     in_a, in_b, out_result;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag, out_tag;
    bit               rdy_force = 1'b1;
    bit               rdy_rand  = 1'b0;
    exp_t             q[$];

    param_nr_divider #(
      .WIDTH          (W),
      .BITS_PER_CYCLE (BPC),
      .TAG_W          (TAG_W),
      .EARLY_OUT      (EO)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .busy       (busy)
    );

    task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("cfg%0d(W%0d/B%0d/E%0d) %s", g, W, BPC, EO, name), act, exp);
    endtask

    // Reference: plain integer division with the documented special cases.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input riscv_div_op_e op, output bit fast);
      longint sa, sb, ma, mb;
      bit sg, dv;
      sg = (op == DIV) || (op == REM);
      dv = (op == DIV) || (op == DIVU);
      if (sg) begin sa = $signed(a); sb = $signed(b); end
      else    begin sa = longint'(a); sb = longint'(b); end
      fast = 1'b1;
      if (op == DIV_NONE) return '0;
      if (b == '0) return dv ? '1 : a;
      if (sg && a == MIN_NEG && b == '1) return dv ? a : '0;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      if (EO != 0 && ma < mb) return dv ? '0 : a;
      fast = 1'b0;
      return dv ? W'(sa / sb) : W'(sa % sb);
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input riscv_div_op_e op,
                         input logic [TAG_W-1:0] tag, input logic [W-1:0] exp_res, input int lat,
                         input bit push, output int acc);
      int w;
      w   = 0;
      acc = -1;
      @(posedge clk); #1;
      in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 300) begin @(negedge clk); w++; end
      if (!in_ready) ck("in_ready wait", in_ready, 1);
      else begin
        acc = cyc;
        if (push) q.push_back('{res: 64'(exp_res), tag: 64'(tag), lat: lat, acc: cyc});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_op = 3'($urandom); in_tag = TAG_W'($urandom);
    endtask

    task automatic drain();
      int w;
      w = 0;
      while ((q.size() != 0 || busy) && w < 500) begin @(negedge clk); w++; end
      ck("drain queue", q.size(), 0);
    endtask

    task automatic wait_valid();
      int w;
      w = 0;
      while (!out_valid && w < 200) begin @(negedge clk); w++; end
    endtask

    initial begin
      out_ready = 1'b0;
      forever begin
        @(posedge clk); #2;
        out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
      end
    end

    initial begin : monitor
      bit seen;
      seen = 1'b0;
      forever begin
        @(negedge clk);
        if (out_valid) begin
          if (q.size() == 0) ck("unexpected out_valid", out_valid, 0);
          else begin
            if (!seen) ck("latency", cyc - q[0].acc, q[0].lat);
            ck("out_result", out_result, q[0].res);
            ck("out_tag", out_tag, q[0].tag);
            ck("in_ready while done", in_ready, 0);
            if (out_ready) void'(q.pop_front());
          end
        end
        seen = out_valid && !out_ready;
      end
    end

    initial begin : drive
      int acc;
      int fcyc;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ck("reset out_valid", out_valid, 0);
      ck("reset busy", busy, 0);
      ck("reset out_result", out_result, 0);
      ck("reset out_tag", out_tag, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      ck("in_ready after reset", in_ready, 1);

      issue(W'(100), W'(7), DIVU, 4'h1, W'(14), NORM, 1, acc);
      issue(W'(100), W'(7), REMU, 4'h2, W'(2), NORM, 1, acc);
      issue(W'(-7), W'(2), DIV, 4'h3, W'(-3), NORM, 1, acc);
      issue(W'(-7), W'(2), REM, 4'h4, W'(-1), NORM, 1, acc);
      issue(W'(7), W'(-2), DIV, 4'h5, W'(-3), NORM, 1, acc);
      issue(W'(5), '0, DIVU, 4'h6, '1, 2, 1, acc);
      issue(W'(5), '0, REM, 4'h7, W'(5), 2, 1, acc);
      issue(MIN_NEG, '1, DIV, 4'h8, MIN_NEG, 2, 1, acc);
      issue(MIN_NEG, '1, REM, 4'h9, '0, 2, 1, acc);
      issue(W'(3), W'(10), REMU, 4'hA, W'(3), (EO != 0) ? 2 : NORM, 1, acc);
      issue(W'(3), W'(10), DIVU, 4'hB, '0, (EO != 0) ? 2 : NORM, 1, acc);
      issue(W'(-3), W'(5), REM, 4'hC, W'(-3), (EO != 0) ? 2 : NORM, 1, acc);
      issue(W'(9), W'(3), DIV_NONE, 4'hD, '0, 2, 1, acc);
      drain();

      // Request presented together with flush must be refused.
      @(posedge clk); #1;
      in_a = W'(9); in_b = W'(3); in_op = DIVU; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      ck("in_ready with flush", in_ready, 0);
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      ck("busy after refused request", busy, 0);

      // Flush an in-flight DIVU, then run a fresh op with a new tag.
      fcyc = (NORM > 12) ? 10 : 3;
      issue(W'(1000), W'(3), DIVU, 4'h6, W'(333), NORM, 0, acc);
      while (cyc < acc + fcyc) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      ck("in_ready during flush", in_ready, 0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      ck("out_valid after flush", out_valid, 0);
      ck("busy after flush", busy, 0);
      ck("in_ready after flush", in_ready, 1);
      repeat (NORM) @(negedge clk);
      issue(W'(9), W'(3), DIVU, 4'h9, W'(3), NORM, 1, acc);
      drain();

      // Output back-pressure: result and tag must hold while out_ready is low.
      rdy_force = 1'b0;
      issue(W'(100), W'(7), DIVU, 4'hE, W'(14), NORM, 1, acc);
      wait_valid();
      repeat (5) @(negedge clk);
      rdy_force = 1'b1;
      drain();

      // Reset during CALC.
      issue(W'(100), W'(7), DIVU, 4'hA, W'(14), NORM, 0, acc);
      while (cyc < acc + 3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      ck("out_valid after mid reset", out_valid, 0);
      ck("busy after mid reset", busy, 0);
      ck("in_ready after mid reset", in_ready, 1);
      ck("out_result after mid reset", out_result, 0);
      ck("out_tag after mid reset", out_tag, 0);

      // flush together with out_ready in S_DONE still transfers the result.
      rdy_force = 1'b0;
      issue(W'(5), '0, DIVU, 4'h3, '1, 2, 1, acc);
      wait_valid();
      @(posedge clk); #1 flush = 1'b1; rdy_force = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      ck("out_valid after flush+ready", out_valid, 0);
      ck("busy after flush+ready", busy, 0);
      ck("queue after flush+ready", q.size(), 0);

      rdy_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
        logic [W-1:0]  a, b, e;
        riscv_div_op_e op;
        bit            fast;
        int            sel;
        sel = $urandom_range(7);
        a = W'($urandom);
        b = W'($urandom);
        case (sel)
          3: begin a = W'(-int'($urandom_range(300))); b = W'(int'($urandom_range(40)) - 20); end
          4: begin a = W'($urandom_range(300)); b = W'($urandom_range(20)); end
          5: b = '0;
          6: begin a = MIN_NEG; b = '1; end
          7: a = W'($urandom_range(50));
          default: begin end
        endcase
        op = riscv_div_op_e'($urandom_range(4));
        e  = ref_res(a, b, op, fast);
        issue(a, b, op, TAG_W'($urandom), e, fast ? 2 : NORM, 1, acc);
        repeat ($urandom_range(2)) @(posedge clk);
      end
      drain();
      n_done++;
    end
  end

  initial begin : main
    int t;
    for (t = 0; t < 60000 && n_done < NCFG; t++) @(posedge clk);
    if (n_done < NCFG) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: %0d configurations finished, required %0d", n_done, NCFG);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
